bus_wait_bridge: RTL and testbench

- Sits between mips_cpu_bus (slave side) and the bus memory model (master side) in the bus testbenches.
- Inserts pseudo-random wait states ahead of each CPU transaction, forwards the transaction once, and returns the memory response.
- Flags CPU bus-protocol violations (request changed while stalled, simultaneous read and write).
- Lets any memory model stress the CPU's waitrequest handling.

---
 rtl/bus_wait_bridge_pkg.sv | 18 +
 rtl/bus_wait_bridge_lfsr16.sv | 31 +++
 rtl/bus_wait_bridge.sv | 166 ++++++++++++++++
 tb/tb_bus_wait_bridge.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_wait_bridge_pkg.sv
// Shared types and LFSR helper for the bus wait-state bridge.
package bus_wait_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ISSUE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_POLY    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // 16-bit Galois LFSR, right shift, taps folded in when the lsb falls out
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/bus_wait_bridge_lfsr16.sv
// Free-running-on-demand 16-bit Galois LFSR; a zero seed is forced to 1
// so the generator never locks up.
module lfsr16
  import bus_wait_bridge_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] state
);

  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= INIT;
    else       lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/bus_wait_bridge.sv
// Inserts pseudo-random CPU wait states ahead of each bus transaction.
// Define BUS_WAIT_BRIDGE_PROTOCOL_CHECK_EN to enable the sticky protocol_error monitor.
module bus_wait_bridge
  import bus_wait_bridge_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED,
  parameter int unsigned WAIT_BITS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [3:0]  s_byteenable,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        s_waitrequest,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [3:0]  m_byteenable,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic [31:0] wait_cycles,
  output logic        protocol_error
);

  localparam logic [WAIT_BITS-1:0] CNT_ONE = 1;

  state_e               state_q, state_d;
  logic [WAIT_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]          cap_addr_q, cap_addr_d;
  logic [3:0]           cap_be_q, cap_be_d;
  logic [31:0]          cap_wdata_q, cap_wdata_d;
  logic                 cap_rd_q, cap_rd_d;
  logic                 cap_wr_q, cap_wr_d;
  logic [31:0]          wait_cycles_q, wait_cycles_d;

  logic [15:0]          lfsr_state;
  logic                 lfsr_adv;
  logic [WAIT_BITS-1:0] n_wait;
  logic                 lfsr_unused;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  assign n_wait      = lfsr_state[WAIT_BITS-1:0];
  assign lfsr_unused = ^lfsr_state[15:WAIT_BITS];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cap_addr_d    = cap_addr_q;
    cap_be_d      = cap_be_q;
    cap_wdata_d   = cap_wdata_q;
    cap_rd_d      = cap_rd_q;
    cap_wr_d      = cap_wr_q;
    lfsr_adv      = 1'b0;
    s_waitrequest = 1'b0;
    s_readdata    = '0;
    m_address     = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_byteenable  = '0;
    m_writedata   = '0;

    case (state_q)
      IDLE: begin
        s_waitrequest = s_read | s_write;
        if (s_read | s_write) begin
          cap_addr_d  = s_address;
          cap_be_d    = s_byteenable;
          cap_wdata_d = s_writedata;
          // a read+write collision resolves to a write
          cap_rd_d    = s_read & ~s_write;
          cap_wr_d    = s_write;
          cnt_d       = n_wait;
          lfsr_adv    = 1'b1;
          state_d     = (n_wait != '0) ? STALL : ISSUE;
        end
      end

      STALL: begin
        s_waitrequest = 1'b1;
        cnt_d         = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = ISSUE;
      end

      ISSUE: begin
        m_address     = cap_addr_q;
        m_read        = cap_rd_q;
        m_write       = cap_wr_q;
        m_byteenable  = cap_be_q;
        m_writedata   = cap_wdata_q;
        s_waitrequest = m_waitrequest;
        if (!m_waitrequest) begin
          if (cap_rd_q) s_readdata = m_readdata;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    wait_cycles_d = wait_cycles_q;
    if (s_waitrequest && (wait_cycles_q != '1)) wait_cycles_d = wait_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cap_addr_q    <= '0;
      cap_be_q      <= '0;
      cap_wdata_q   <= '0;
      cap_rd_q      <= 1'b0;
      cap_wr_q      <= 1'b0;
      wait_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cap_addr_q    <= cap_addr_d;
      cap_be_q      <= cap_be_d;
      cap_wdata_q   <= cap_wdata_d;
      cap_rd_q      <= cap_rd_d;
      cap_wr_q      <= cap_wr_d;
      wait_cycles_q <= wait_cycles_d;
    end
  end

  assign wait_cycles = wait_cycles_q;

`ifdef BUS_WAIT_BRIDGE_PROTOCOL_CHECK_EN
  logic perr_q, perr_d;
  logic req_changed;

  // while a transaction is outstanding the CPU must hold its request steady
  always_comb begin
    req_changed = (s_address    != cap_addr_q)  ||
                  (s_byteenable != cap_be_q)    ||
                  (s_writedata  != cap_wdata_q) ||
                  (s_read       != cap_rd_q)    ||
                  (s_write      != cap_wr_q);
    perr_d = perr_q;
    if ((state_q == IDLE) && s_read && s_write) perr_d = 1'b1;
    if ((state_q != IDLE) && req_changed)       perr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end

  assign protocol_error = perr_q;
`else
  assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_bus_wait_bridge.sv
// Scoreboard bench for bus_wait_bridge with a stalling memory responder.
module tb_bus_wait_bridge;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int unsigned WB   = 3;
`ifdef BUS_WAIT_BRIDGE_PROTOCOL_CHECK_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  logic        clk, reset;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable, m_byteenable;
  logic [31:0] m_address, m_writedata, m_readdata;
  logic        m_read, m_write, m_waitrequest;
  logic [31:0] wait_cycles;
  logic        protocol_error;

  int unsigned mem_waits, mem_cnt;
  logic [31:0] mem_rdata;

  typedef struct {
    int unsigned waits;
    int unsigned mcyc;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks, n_errors;
  logic [15:0] model_lfsr;
  int unsigned tot_waits;

  bus_wait_bridge #(.LFSR_SEED(SEED), .WAIT_BITS(WB)) dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .wait_cycles(wait_cycles), .protocol_error(protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory responder: stalls mem_waits cycles of every access it sees
  assign m_waitrequest = (m_read | m_write) && (mem_cnt < mem_waits);
  assign m_readdata    = mem_rdata;
  always @(posedge clk) begin
    if ((m_read | m_write) && m_waitrequest) mem_cnt <= mem_cnt + 1;
    else                                    mem_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic do_xact(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input int unsigned memw, input logic [31:0] mrd,
                         input bit perturb);
    exp_t        e;
    int unsigned n, waits, mcyc;
    bit          done, mirror_bad, leak, idle_bad, perturbed;
    logic [31:0] seen_addr, seen_wd, got_rdata;
    logic [3:0]  seen_be;
    logic        seen_rd, seen_wr;
    waits = 0; mcyc = 0; done = 0; mirror_bad = 0; leak = 0; idle_bad = 0; perturbed = 0;
    seen_addr = '0; seen_wd = '0; seen_be = '0; seen_rd = 0; seen_wr = 0; got_rdata = '0;

    n = model_lfsr % (1 << WB);
    model_lfsr = lfsr_step(model_lfsr);
    e.waits = 1 + n + memw;
    e.mcyc  = memw + 1;
    e.rd    = rd & ~wr;
    e.wr    = wr;
    e.rdata = (rd & ~wr) ? mrd : 32'h0;
    e.addr  = addr; e.wdata = wd; e.be = be;
    exp_q.push_back(e);

    mem_waits = memw; mem_rdata = mrd;
    s_address = addr; s_byteenable = be; s_writedata = wd;
    s_read = rd; s_write = wr;

    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (m_read || m_write) begin
        mcyc++;
        seen_addr = m_address; seen_wd = m_writedata; seen_be = m_byteenable;
        seen_rd = m_read; seen_wr = m_write;
        if (s_waitrequest !== m_waitrequest) mirror_bad = 1;
      end else if (m_address !== '0 || m_writedata !== '0 || m_byteenable !== '0) begin
        idle_bad = 1;
      end
      if (s_waitrequest) begin
        waits++;
        if (s_readdata !== '0) leak = 1;
      end else begin
        done = 1;
        got_rdata = s_readdata;
      end
      if (!done) begin
        @(posedge clk); #1;
        if (perturb && !perturbed) begin
          s_address = addr ^ 32'h0000_0100;
          perturbed = 1;
        end
      end
    end

    chk("xact_done", {31'b0, done}, 32'd1);
    e = exp_q.pop_front();
    tot_waits += e.waits;
    chk("waits", waits, e.waits);
    chk("rdata", got_rdata, e.rdata);
    chk("m_cycles", mcyc, e.mcyc);
    chk("m_address", seen_addr, e.addr);
    chk("m_writedata", seen_wd, e.wdata);
    chk("m_byteenable", {28'b0, seen_be}, {28'b0, e.be});
    chk("m_read", {31'b0, seen_rd}, {31'b0, e.rd});
    chk("m_write", {31'b0, seen_wr}, {31'b0, e.wr});
    chk("wait_mirror", {31'b0, mirror_bad}, 32'd0);
    chk("rdata_leak", {31'b0, leak}, 32'd0);
    chk("m_idle_zero", {31'b0, idle_bad}, 32'd0);
    chk("wait_cycles", wait_cycles, tot_waits);

    @(posedge clk); #1;
    s_read = 1'b0; s_write = 1'b0;
  endtask

  initial begin
    bit reached;
    n_checks = 0; n_errors = 0;
    model_lfsr = SEED; tot_waits = 0;
    mem_waits = 0; mem_rdata = '0;
    s_address = '0; s_read = 0; s_write = 0; s_byteenable = '0; s_writedata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_waitreq", {31'b0, s_waitrequest}, 32'd0);
    chk("rst_m_rw", {30'b0, m_read, m_write}, 32'd0);
    chk("rst_readdata", s_readdata, 32'd0);
    chk("rst_wait_cycles", wait_cycles, 32'd0);
    chk("rst_perr", {31'b0, protocol_error}, 32'd0);
    @(posedge clk); #1;

    do_xact(32'h0000_0010, 1, 0, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 0);
    do_xact(32'h0000_0020, 0, 1, 4'b0011, 32'h1234_5678, 0, 32'h0, 0);
    chk("wait_total_3", wait_cycles, 32'd3);
    do_xact(32'h0000_0030, 1, 0, 4'hF, 32'hA5A5_0000, 4, 32'hCAFE_F00D, 0);
    chk("perr_clean", {31'b0, protocol_error}, 32'd0);
    do_xact(32'h0000_0080, 0, 1, 4'b1100, 32'h0BAD_F00D, 1, 32'h0, 1);
    chk("perr_addr_change", {31'b0, protocol_error}, {31'b0, PE});
    @(posedge clk); #1;
    chk("perr_sticky", {31'b0, protocol_error}, {31'b0, PE});

    // reset in the middle of ISSUE
    model_lfsr = lfsr_step(model_lfsr);
    mem_waits = 10; mem_rdata = 32'h1111_2222;
    s_address = 32'h0000_0040; s_byteenable = 4'hF; s_writedata = '0;
    s_read = 1'b1;
    reached = 0;
    for (int c = 0; c < 50 && !reached; c++) begin
      @(negedge clk);
      if (m_read) reached = 1;
    end
    chk("reach_issue", {31'b0, reached}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_m_read", {31'b0, m_read}, 32'd0);
    chk("rst_async_wait_cycles", wait_cycles, 32'd0);
    chk("rst_async_perr", {31'b0, protocol_error}, 32'd0);
    @(posedge clk); #1;
    s_read = 1'b0; reset = 1'b0;
    model_lfsr = SEED; tot_waits = 0;
    @(posedge clk); #1;

    do_xact(32'h0000_0010, 1, 0, 4'hF, 32'h0, 0, 32'h5555_AAAA, 0);
    chk("perr_after_rst", {31'b0, protocol_error}, 32'd0);
    do_xact(32'h0000_0044, 1, 1, 4'hF, 32'h7777_8888, 0, 32'h9999_0000, 0);
    chk("perr_rd_wr", {31'b0, protocol_error}, {31'b0, PE});

    for (int i = 0; i < 6; i++) begin
      logic rd;
      rd = 1'($urandom_range(0, 1));
      do_xact($urandom & 32'hFFFF_FFFC, rd, ~rd, 4'($urandom), $urandom,
              $urandom_range(0, 3), $urandom, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
